// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state codes and the 12-bit control word.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // First field is the MSB of the packed word.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = 12'b0011_1110_0011;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter; synchronous clear to T1, hold freezes the current state.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr_bar,
    input  logic       hold,
    output logic [5:0] t_state
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            state_d = {state_q[4:0], state_q[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, halt latch and microinstruction decode.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic       CLK_bar,
    input  logic       CLR_bar,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_bar,
    output logic       CE_bar,
    output logic       Li_bar,
    output logic       Ei_bar,
    output logic       La_bar,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb_bar,
    output logic       Lo_bar,
    output logic       HLT,
    output logic [5:0] t_state
);

    logic       halted_q;
    logic       halted_d;
    logic       halt_set;
    ctrl_word_t cw;
    logic       hlt;

    // Holding the ring on the setting edge keeps t_state parked at T4.
    assign halt_set = (t_state == T4) && (opcode == OP_HLT) && !halted_q;

    always_comb begin
        halted_d = halted_q | halt_set;
    end

    always_ff @(posedge CLK_bar) begin
        if (!CLR_bar) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    ring_counter u_ring (
        .clk     (CLK_bar),
        .clr_bar (CLR_bar),
        .hold    (halted_q | halt_set),
        .t_state (t_state)
    );

    always_comb begin
        cw  = CW_IDLE;
        hlt = halted_q;
        if (!CLR_bar) begin
            cw  = CW_IDLE;
            hlt = 1'b0;
        end else if (!halted_q) begin
            case (t_state)
                T1: begin
                    cw.ep     = 1'b1;
                    cw.lm_bar = 1'b0;
                end
                T2: cw.cp = 1'b1;
                T3: begin
                    cw.ce_bar = 1'b0;
                    cw.li_bar = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.ei_bar = 1'b0;
                            cw.lm_bar = 1'b0;
                        end
                        OP_OUT: begin
                            cw.ea     = 1'b1;
                            cw.lo_bar = 1'b0;
                        end
                        OP_HLT:  hlt = 1'b1;
                        default: cw = CW_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            cw.ce_bar = 1'b0;
                            cw.la_bar = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.ce_bar = 1'b0;
                            cw.lb_bar = 1'b0;
                            cw.su     = (opcode == OP_SUB);
                        end
                        default: cw = CW_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            cw.eu     = 1'b1;
                            cw.la_bar = 1'b0;
                            cw.su     = (opcode == OP_SUB);
                        end
                        default: cw = CW_IDLE;
                    endcase
                end
                default: cw = CW_IDLE;
            endcase
        end
    end

    assign Cp     = cw.cp;
    assign Ep     = cw.ep;
    assign Lm_bar = cw.lm_bar;
    assign CE_bar = cw.ce_bar;
    assign Li_bar = cw.li_bar;
    assign Ei_bar = cw.ei_bar;
    assign La_bar = cw.la_bar;
    assign Ea     = cw.ea;
    assign Su     = cw.su;
    assign Eu     = cw.eu;
    assign Lb_bar = cw.lb_bar;
    assign Lo_bar = cw.lo_bar;
    assign HLT    = hlt;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed table-driven bench for controller_sequencer with hand-computed control words.
module tb_controller_sequencer;

    // Control word bit order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
    localparam logic [11:0] CW_I    = 12'h3E3;
    localparam logic [11:0] CW_T1   = 12'h5E3;
    localparam logic [11:0] CW_T2   = 12'hBE3;
    localparam logic [11:0] CW_T3   = 12'h263;
    localparam logic [11:0] CW_MAR  = 12'h1A3;
    localparam logic [11:0] CW_LDA5 = 12'h2C3;
    localparam logic [11:0] CW_ADD5 = 12'h2E1;
    localparam logic [11:0] CW_SUB5 = 12'h2E9;
    localparam logic [11:0] CW_ADD6 = 12'h3C7;
    localparam logic [11:0] CW_SUB6 = 12'h3CF;
    localparam logic [11:0] CW_OUT4 = 12'h3F2;

    typedef struct {
        logic        clr;
        logic [3:0]  op;
        logic        chk_t;
        logic [5:0]  t;
        logic [11:0] cw;
        logic        hlt;
        string       name;
    } vec_t;

    logic       clk;
    logic       clr_bar;
    logic [3:0] opcode;
    logic       cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar;
    logic       hlt;
    logic [5:0] t_state;

    int   checks;
    int   errors;
    vec_t vecs[$];

    controller_sequencer dut (
        .CLK_bar (clk),
        .CLR_bar (clr_bar),
        .opcode  (opcode),
        .Cp      (cp),
        .Ep      (ep),
        .Lm_bar  (lm_bar),
        .CE_bar  (ce_bar),
        .Li_bar  (li_bar),
        .Ei_bar  (ei_bar),
        .La_bar  (la_bar),
        .Ea      (ea),
        .Su      (su),
        .Eu      (eu),
        .Lb_bar  (lb_bar),
        .Lo_bar  (lo_bar),
        .HLT     (hlt),
        .t_state (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic clr, input logic [3:0] op, input logic chk_t,
                                input logic [5:0] t, input logic [11:0] cw, input logic h,
                                input string name);
        vec_t v;
        v.clr = clr; v.op = op; v.chk_t = chk_t; v.t = t; v.cw = cw; v.hlt = h; v.name = name;
        return v;
    endfunction

    task automatic add(input logic clr, input logic [3:0] op, input logic [5:0] t,
                       input logic [11:0] cw, input logic h, input string name);
        vecs.push_back(mk(clr, op, 1'b1, t, cw, h, name));
    endtask

    // Fetch rows use fop (to show opcode is ignored in T1-T3), execute rows use op.
    task automatic add_instr(input logic [3:0] fop, input logic [3:0] op, input logic [11:0] c4,
                             input logic [11:0] c5, input logic [11:0] c6, input string name);
        add(1'b1, fop, 6'b000001, CW_T1, 1'b0, {name, "_t1"});
        add(1'b1, fop, 6'b000010, CW_T2, 1'b0, {name, "_t2"});
        add(1'b1, fop, 6'b000100, CW_T3, 1'b0, {name, "_t3"});
        add(1'b1, op,  6'b001000, c4,    1'b0, {name, "_t4"});
        add(1'b1, op,  6'b010000, c5,    1'b0, {name, "_t5"});
        add(1'b1, op,  6'b100000, c6,    1'b0, {name, "_t6"});
    endtask

    // Drive inputs, check settled outputs mid-low-phase, then take one clock edge.
    task automatic step(input vec_t v);
        logic [11:0] act_cw;
        clr_bar = v.clr;
        opcode  = v.op;
        #1;
        act_cw = {cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar};
        checks++;
        if (act_cw !== v.cw || hlt !== v.hlt || (v.chk_t && t_state !== v.t)) begin
            errors++;
            $display("FAIL %s: got t=%b cw=%h hlt=%b, expected t=%b cw=%h hlt=%b",
                     v.name, t_state, act_cw, hlt, v.t, v.cw, v.hlt);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clr_bar = 1'b0;
        opcode  = 4'b0000;

        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 6'b000000, CW_I, 1'b0, "reset_asserted"));
        add(1'b0, 4'h0, 6'b000001, CW_I, 1'b0, "reset_t1_idle");
        add_instr(4'h0, 4'h0, CW_MAR, CW_LDA5, CW_I, "lda_a");
        add_instr(4'hF, 4'h0, CW_MAR, CW_LDA5, CW_I, "lda_b_fetch_op_ignored");
        add_instr(4'h1, 4'h1, CW_MAR, CW_ADD5, CW_ADD6, "add");
        add_instr(4'h2, 4'h2, CW_MAR, CW_SUB5, CW_SUB6, "sub");
        add_instr(4'hE, 4'hE, CW_OUT4, CW_I, CW_I, "out");
        add_instr(4'h5, 4'h5, CW_I, CW_I, CW_I, "undef");
        add(1'b1, 4'h5, 6'b000001, CW_T1, 1'b0, "after_undef_t1");
        add(1'b1, 4'h1, 6'b000010, CW_T2, 1'b0, "rst_add_t2");
        add(1'b1, 4'h1, 6'b000100, CW_T3, 1'b0, "rst_add_t3");
        add(1'b1, 4'h1, 6'b001000, CW_MAR, 1'b0, "rst_add_t4");
        add(1'b0, 4'h1, 6'b010000, CW_I, 1'b0, "rst_in_t5_forced_idle");
        add(1'b0, 4'h1, 6'b000001, CW_I, 1'b0, "rst_in_t5_to_t1");
        add(1'b1, 4'h1, 6'b000001, CW_T1, 1'b0, "rst_release_t1");
        add(1'b1, 4'h1, 6'b000010, CW_T2, 1'b0, "rst_release_t2");

        foreach (vecs[i]) step(vecs[i]);

        // Halt sequence: enter HLT, stay parked for 10 clocks with opcode toggling.
        step(mk(1'b0, 4'hF, 1'b0, 6'b000000, CW_I, 1'b0, "hlt_reset"));
        step(mk(1'b1, 4'hF, 1'b1, 6'b000001, CW_T1, 1'b0, "hlt_t1"));
        step(mk(1'b1, 4'hF, 1'b1, 6'b000010, CW_T2, 1'b0, "hlt_t2"));
        step(mk(1'b1, 4'hF, 1'b1, 6'b000100, CW_T3, 1'b0, "hlt_t3"));
        step(mk(1'b1, 4'hF, 1'b1, 6'b001000, CW_I, 1'b1, "hlt_t4_decode"));
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op;
            op = 4'(i * 5 + 1);
            step(mk(1'b1, op, 1'b1, 6'b001000, CW_I, 1'b1, "halted_frozen"));
        end

        // Reset while halted.
        step(mk(1'b0, 4'h1, 1'b1, 6'b001000, CW_I, 1'b0, "halted_reset_forced"));
        step(mk(1'b0, 4'h1, 1'b1, 6'b000001, CW_I, 1'b0, "halted_reset_t1"));
        step(mk(1'b1, 4'h1, 1'b1, 6'b000001, CW_T1, 1'b0, "halted_release_t1"));
        step(mk(1'b1, 4'h1, 1'b1, 6'b000010, CW_T2, 1'b0, "halted_release_t2"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) plus microinstruction decoder that drives the 12-bit control word for the program counter, MAR, RAM, instruction register, accumulator, adder/subtracter, B and output registers. It sequences fetch (T1–T3) and execute (T4–T6) for LDA, ADD, SUB, OUT and HLT. It latches a halt condition that freezes the machine until reset.

## Interface
- No parameters. Opcode values, T-state encodings and control-bit positions are fixed by `sap1_pkg`.
- `CLK_bar` input 1: system clock. State advances on its rising edge, the same edge the program counter uses.
- `CLR_bar` input 1: reset, synchronous, active-low.
- `opcode` input 4: upper nibble of the instruction register; only sampled during T4–T6.
- `Cp`, `Ep` output 1 each: PC increment and PC enable, active-high.
- `Lm_bar`, `CE_bar`, `Li_bar`, `Ei_bar`, `La_bar`, `Lb_bar`, `Lo_bar` output 1 each: active-low loads and enables for MAR, RAM, IR, IR-address, A, B and OUT.
- `Ea`, `Su`, `Eu` output 1 each: accumulator enable, subtract select and adder enable, active-high.
- `HLT` output 1: high while halted, or while decoding HLT in T4.
- `t_state` output 6: one-hot ring state, bit 0 = T1.

## Operation
- Inactive control word: all active-high signals 0 and all active-low signals 1.
- Ring counter sequence: T1→T2→…→T6→T1, one state per clock.
- Fetch cycle, independent of `opcode`:
  - T1: `Ep`, `Lm_bar`=0.
  - T2: `Cp`.
  - T3: `CE_bar`=0, `Li_bar`=0.
- Execute cycle:
  - LDA (0000): T4 `Ei_bar`=0, `Lm_bar`=0. T5 `CE_bar`=0, `La_bar`=0. T6 no-op.
  - ADD (0001): T4 `Ei_bar`=0, `Lm_bar`=0. T5 `CE_bar`=0, `Lb_bar`=0. T6 `Eu`, `La_bar`=0, `Su`=0.
  - SUB (0010): same as ADD, except `Su`=1 in T5 and T6.
  - OUT (1110): T4 `Ea`, `Lo_bar`=0. T5 and T6 no-op.
  - HLT (1111): T4 drives the inactive control word and `HLT`=1. The halted flag sets on the T4 clock edge.
  - Any other opcode: T4–T6 no-op, so the fetch of the next instruction proceeds normally.
- Halted state:
  - `t_state` frozen at T4; control word inactive; `HLT`=1.
  - `opcode` is ignored.
  - Only `CLR_bar` exits the halted state.
- Control word is combinational decode of the registered `t_state`, halted flag and `opcode`. No output is registered separately.

## Timing
- Reset, sampled on a `CLK_bar` rising edge with `CLR_bar`=0:
  - `t_state`=000001 (T1); halted flag=0.
  - While `CLR_bar`=0, the control word is forced inactive and `HLT`=0.
- First fetch: the first rising edge with `CLR_bar`=1 advances to T2. T1 control is visible in the cycle immediately after reset is released.
- Latency: each instruction takes exactly 6 clocks. Next T1 follows T6 on the next edge; there are no wait states.
- `Cp` is high for exactly one cycle per instruction (T2), so the PC increments on the T2→T3 edge.
- HLT: `HLT` rises combinationally in T4 and stays high from the T4 edge onward.
- Reset mid-instruction, at any T-state or while halted: the next edge gives T1 with the halted flag cleared.
- `opcode` changing during T1–T3 has no effect on outputs.

## Structure
- `sap1_pkg`:
  - Opcode enum: `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`.
  - T-state one-hot localparams `T1`..`T6`.
  - Packed control-word struct, 12 bits in the order Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar.
  - `CW_IDLE` constant holding the inactive word.
- Sub-module `ring_counter`: 6-bit one-hot shifter with synchronous clear to T1 and a hold input driven by the halted flag.
- Top level: halted-flag register and case-based decode to the control-word struct.

## Test plan
- Reset then 12 clocks, `opcode`=0000: `t_state` cycles 000001…100000 twice; `Cp` high only in the 2nd and 8th cycles; `La_bar`=0 only in T5.
- ADD then SUB: ADD drives `Su`=0 in T6 with `Eu`=1, `La_bar`=0. SUB drives `Su`=1 in T5 and T6, with the same `Eu`/`La_bar`.
- OUT (1110): in T4 `Ea`=1 and `Lo_bar`=0, with all other signals inactive; T5 and T6 are fully inactive.
- HLT (1111): `HLT`=1 in T4. After 10 further clocks, `t_state`=001000, the control word equals `CW_IDLE` and `HLT`=1. Toggling `opcode` changes nothing.
- Reset mid-operation: assert `CLR_bar`=0 in T5 of ADD, and separately while halted. The next edge gives T1 with `HLT`=0, and the control word stays inactive until release.
- Undefined opcode (0101): T4–T6 fully inactive, and the next T1 shows `Ep`=1, `Lm_bar`=0.
